lsu_dccm_stbuf: RTL and testbench

- Committed-store buffer directly upstream of the DCCM write port.
- Accepts retired, already-merged doubleword stores from the DC4 commit stage and holds them in a small FIFO.
- Drains one entry per cycle into dccm_wren/dccm_wr_addr/dccm_wr_data whenever the target bank is not being read by the load pipe.
- Supplies store-to-load forwarding (or a hazard flag) for loads in DC1.

---
 rtl/lsu_dccm_stbuf_if.sv | 18 +
 rtl/lsu_dccm_stbuf.sv | 158 +++++++++++++++
 tb/tb_lsu_dccm_stbuf.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dccm_stbuf_if.sv
// Store-commit channel between the DC4 commit stage and the DCCM store buffer.
//   st_valid : committed store offered (master -> slave)
//   st_ready : buffer can accept this cycle (slave -> master)
//   st_addr  : store byte address; the low three bits are ignored
//   st_data  : full merged doubleword
// master = commit stage, slave = store buffer.
interface lsu_dccm_stbuf_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;

    modport master (output st_valid, st_addr, st_data, input st_ready);
    modport slave  (input st_valid, st_addr, st_data, output st_ready);
endinterface

// File: rtl/lsu_dccm_stbuf.sv
// Committed-store buffer in front of the DCCM write port.
// Holds retired doubleword stores in a small circular FIFO and drains one per
// cycle whenever the head entry's bank is not being read by the DC1 load.
// A store to the same doubleword as the youngest entry coalesces into it.
// DC1 loads are checked against all buffered stores for forwarding.
//
// Optional feature macro: LSU_STBUF_FWD_EN
//   defined   : fwd_hit_*/fwd_data_* return the youngest matching store, rd_hazard = 0
//   undefined : fwd_* tied 0 (no data mux); rd_hazard flags any match so the pipe stalls
//
// Ports:
//   clk, rst_l           clock, asynchronous active-low reset
//   lsu_freeze_dc3       blocks the drain
//   st (slave)           store-commit channel (st_valid/st_ready/st_addr/st_data)
//   ld_rden_dc1          load pipe reading DCCM this cycle
//   ld_addr_lo/hi_dc1    load lo/hi bank addresses
//   dccm_wren/_wr_addr/_wr_data  DCCM write port (head entry)
//   fwd_hit_lo/hi, fwd_data_lo/hi  forwarding results, qualified by ld_rden_dc1
//   rd_hazard            match present while forwarding is not built
//   stbuf_empty          no buffered stores
module lsu_dccm_stbuf #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter int BANK_BITS = 3
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               lsu_freeze_dc3,
    lsu_dccm_stbuf_if.slave    st,
    input  logic               ld_rden_dc1,
    input  logic [ADDR_W-1:0]  ld_addr_lo_dc1,
    input  logic [ADDR_W-1:0]  ld_addr_hi_dc1,
    output logic               dccm_wren,
    output logic [ADDR_W-1:0]  dccm_wr_addr,
    output logic [DATA_W-1:0]  dccm_wr_data,
    output logic               fwd_hit_lo,
    output logic               fwd_hit_hi,
    output logic [DATA_W-1:0]  fwd_data_lo,
    output logic [DATA_W-1:0]  fwd_data_hi,
    output logic               rd_hazard,
    output logic               stbuf_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int DW_W  = ADDR_W - 3;

    typedef struct packed {
        logic [DW_W-1:0]   dw;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q;
    logic   [DEPTH-1:0] valid_q;
    logic   [PTR_W-1:0] head_q, tail_q, young;
    logic   [PTR_W:0]   count_q;

    logic push, pop, coalesce, push_new, conflict;
    logic [BANK_BITS-1:0] wr_bank;
    logic [DEPTH-1:0] match_lo, match_hi;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{st.st_addr[2:0], ld_addr_lo_dc1[2:0], ld_addr_hi_dc1[2:0]};

    assign st.st_ready = (count_q != (PTR_W+1)'(DEPTH));
    assign stbuf_empty = (count_q == '0);

    // Drain: head entry goes out unless frozen or its bank is being read.
    assign wr_bank      = ent_q[head_q].dw[BANK_BITS-1:0];
    assign conflict     = ld_rden_dc1 & ((wr_bank == ld_addr_lo_dc1[3 +: BANK_BITS]) |
                                         (wr_bank == ld_addr_hi_dc1[3 +: BANK_BITS]));
    assign dccm_wren    = valid_q[head_q] & ~lsu_freeze_dc3 & ~conflict;
    assign dccm_wr_addr = {ent_q[head_q].dw, 3'b000};
    assign dccm_wr_data = ent_q[head_q].data;
    assign pop          = dccm_wren;

    // Coalesce into the youngest entry, unless that entry is leaving this cycle
    // (then the store must take a fresh slot so it is not lost).
    assign push     = st.st_valid & st.st_ready;
    assign young    = tail_q - PTR_W'(1);
    assign coalesce = push & valid_q[young] & (ent_q[young].dw == st.st_addr[ADDR_W-1:3]) &
                      ~(pop & (head_q == young));
    assign push_new = push & ~coalesce;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (push_new) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(push_new) - (PTR_W+1)'(pop);
        end
    end

    // Payload needs no reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push_new)
            ent_q[tail_q] <= {st.st_addr[ADDR_W-1:3], st.st_data};
        else if (coalesce)
            ent_q[young].data <= st.st_data;
    end

    always_comb begin
        match_lo = '0;
        match_hi = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_lo[i] = valid_q[i] & (ent_q[i].dw == ld_addr_lo_dc1[ADDR_W-1:3]);
            match_hi[i] = valid_q[i] & (ent_q[i].dw == ld_addr_hi_dc1[ADDR_W-1:3]);
        end
    end

`ifdef LSU_STBUF_FWD_EN
    logic [PTR_W-1:0]  idx;
    logic              sel_hit_lo, sel_hit_hi;
    logic [DATA_W-1:0] sel_data_lo, sel_data_hi;

    // Walk oldest to youngest from head; a later match overrides, so the
    // youngest matching store wins. Invalid slots are skipped by match_*.
    always_comb begin
        sel_hit_lo  = 1'b0;
        sel_hit_hi  = 1'b0;
        sel_data_lo = '0;
        sel_data_hi = '0;
        idx         = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (match_lo[idx]) begin
                sel_hit_lo  = 1'b1;
                sel_data_lo = ent_q[idx].data;
            end
            if (match_hi[idx]) begin
                sel_hit_hi  = 1'b1;
                sel_data_hi = ent_q[idx].data;
            end
        end
    end

    assign fwd_hit_lo  = ld_rden_dc1 & sel_hit_lo;
    assign fwd_hit_hi  = ld_rden_dc1 & sel_hit_hi;
    assign fwd_data_lo = ld_rden_dc1 ? sel_data_lo : '0;
    assign fwd_data_hi = ld_rden_dc1 ? sel_data_hi : '0;
    assign rd_hazard   = 1'b0;
`else
    assign fwd_hit_lo  = 1'b0;
    assign fwd_hit_hi  = 1'b0;
    assign fwd_data_lo = '0;
    assign fwd_data_hi = '0;
    assign rd_hazard   = ld_rden_dc1 & ((|match_lo) | (|match_hi));
`endif
endmodule

// File: tb/tb_lsu_dccm_stbuf.sv
module tb_lsu_dccm_stbuf;
    localparam int DEPTH = 4, ADDR_W = 16, DATA_W = 64, BANK_BITS = 3;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic              freeze = 1'b0;
    logic              ld = 1'b0;
    logic [ADDR_W-1:0] lo = '0, hi = '0;
    logic              dccm_wren, fwd_hit_lo, fwd_hit_hi, rd_hazard, stbuf_empty;
    logic [ADDR_W-1:0] dccm_wr_addr;
    logic [DATA_W-1:0] dccm_wr_data, fwd_data_lo, fwd_data_hi;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_dccm_stbuf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) st_if();

    lsu_dccm_stbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK_BITS(BANK_BITS)) dut (
        .clk(clk), .rst_l(rst_l), .lsu_freeze_dc3(freeze), .st(st_if.slave),
        .ld_rden_dc1(ld), .ld_addr_lo_dc1(lo), .ld_addr_hi_dc1(hi),
        .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
        .fwd_hit_lo(fwd_hit_lo), .fwd_hit_hi(fwd_hit_hi),
        .fwd_data_lo(fwd_data_lo), .fwd_data_hi(fwd_data_hi),
        .rd_hazard(rd_hazard), .stbuf_empty(stbuf_empty)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Forwarding expectations differ by build; m* are matches already qualified by the load.
    task automatic chk_fwd(input string tag, input logic mlo, input logic [63:0] mdlo,
                           input logic mhi, input logic [63:0] mdhi);
`ifdef LSU_STBUF_FWD_EN
        chk({tag, ".hit_lo"}, 64'(fwd_hit_lo), 64'(mlo));
        chk({tag, ".hit_hi"}, 64'(fwd_hit_hi), 64'(mhi));
        chk({tag, ".data_lo"}, fwd_data_lo, mlo ? mdlo : 64'h0);
        chk({tag, ".data_hi"}, fwd_data_hi, mhi ? mdhi : 64'h0);
        chk({tag, ".hazard"}, 64'(rd_hazard), 64'h0);
`else
        chk({tag, ".hit_lo"}, 64'(fwd_hit_lo), 64'h0);
        chk({tag, ".hit_hi"}, 64'(fwd_hit_hi), 64'h0);
        chk({tag, ".data_lo"}, fwd_data_lo, 64'h0);
        chk({tag, ".data_hi"}, fwd_data_hi, 64'h0);
        chk({tag, ".hazard"}, 64'(rd_hazard), 64'(mlo | mhi));
`endif
    endtask

    task automatic drive(input logic sv, input logic [15:0] sa, input logic [63:0] sd,
                         input logic frz, input logic l, input logic [15:0] a_lo, input logic [15:0] a_hi);
        st_if.st_valid = sv; st_if.st_addr = sa; st_if.st_data = sd;
        freeze = frz; ld = l; lo = a_lo; hi = a_hi;
    endtask

    typedef struct {
        logic sv; logic [15:0] sa; logic [63:0] sd; logic frz; logic ld;
        logic [15:0] lo; logic [15:0] hi;
        logic er; logic ee; logic ew; logic [15:0] ewa; logic [63:0] ewd;
        logic mlo; logic [63:0] mdlo; logic mhi;
    } vec_t;

    function automatic vec_t mk(input logic sv, input logic [15:0] sa, input logic [63:0] sd,
                                input logic frz, input logic l, input logic [15:0] a_lo, input logic [15:0] a_hi,
                                input logic er, input logic ee, input logic ew,
                                input logic [15:0] ewa, input logic [63:0] ewd,
                                input logic mlo, input logic [63:0] mdlo, input logic mhi);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.frz = frz; v.ld = l; v.lo = a_lo; v.hi = a_hi;
        v.er = er; v.ee = ee; v.ew = ew; v.ewa = ewa; v.ewd = ewd;
        v.mlo = mlo; v.mdlo = mdlo; v.mhi = mhi;
        return v;
    endfunction

    typedef struct { logic [12:0] a; logic [63:0] d; } ment_t;
    ment_t q[$];

    function automatic logic [15:0] rnd_addr();
        logic [15:0] a;
        a = (16'($urandom_range(0, 15)) << 3) | 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 1)) << 12);
        return a;
    endfunction

    vec_t vecs[$];

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset.ready", 64'(st_if.st_ready), 64'h1);
        chk("reset.empty", 64'(stbuf_empty), 64'h1);
        chk("reset.wren", 64'(dccm_wren), 64'h0);
        chk_fwd("reset", 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_l = 1'b1;

        //        sv sa       sd                     frz ld lo       hi       er ee ew ewa      ewd                    mlo mdlo  mhi
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0108, 64'hA5A5_0000_1111_2222, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,          0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0108, 64'hA5A5_0000_1111_2222, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0000, 64'h10,               1, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0010, 64'h11,               1, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0020, 64'h12,               1, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0030, 64'h13,               1, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0040, 64'h14,               1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0040, 64'h14,               0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 64'h10,               0, 0,     0));
        vecs.push_back(mk(1, 16'h0040, 64'h14,               0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0010, 64'h11,               0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0020, 64'h12,               0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0030, 64'h13,               0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0040, 64'h14,               0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0108, 64'h1,                0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 1, 16'h0108, 16'h0110, 1, 0, 0, 16'h0000, 64'h0,                1, 64'h1, 0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0108, 16'h0110, 1, 0, 1, 16'h0108, 64'h1,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0200, 64'h1,                1, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0200, 64'h2,                1, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0200, 64'h2,                0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0300, 64'hAA,               1, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0400, 64'h11,               1, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0300, 64'hBB,               1, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                1, 1, 16'h0304, 16'h0500, 1, 0, 0, 16'h0000, 64'h0,                1, 64'hBB, 0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0304, 16'h0500, 1, 0, 1, 16'h0300, 64'hAA,               0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0400, 64'h11,               0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0300, 64'hBB,               0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(1, 16'h0108, 64'h7,                0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 1, 16'h0000, 16'h0148, 1, 0, 0, 16'h0000, 64'h0,                0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 1, 16'h0000, 16'h0010, 1, 0, 1, 16'h0108, 64'h7,                0, 0,     0));
        vecs.push_back(mk(0, 16'h0000, 64'h0,                0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 64'h0,                0, 0,     0));

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("v%0d", i);
            drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].frz, vecs[i].ld, vecs[i].lo, vecs[i].hi);
            #1;
            chk({t, ".ready"}, 64'(st_if.st_ready), 64'(vecs[i].er));
            chk({t, ".empty"}, 64'(stbuf_empty), 64'(vecs[i].ee));
            chk({t, ".wren"}, 64'(dccm_wren), 64'(vecs[i].ew));
            if (vecs[i].ew) begin
                chk({t, ".waddr"}, 64'(dccm_wr_addr), 64'(vecs[i].ewa));
                chk({t, ".wdata"}, dccm_wr_data, vecs[i].ewd);
            end
            chk_fwd(t, vecs[i].mlo, vecs[i].mdlo, vecs[i].mhi, 64'h0);
            @(posedge clk); #1;
        end

        // Asynchronous reset with three stores buffered, mid-drain.
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'(16'h0600 + 16'(i * 8)), 64'(i + 1), 1, 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ares.wren_before", 64'(dccm_wren), 64'h1);
        #2;
        rst_l = 1'b0;
        #1;
        chk("ares.wren_now", 64'(dccm_wren), 64'h0);
        chk("ares.empty_now", 64'(stbuf_empty), 64'h1);
        @(posedge clk); #1;
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("ares.wren_after%0d", i), 64'(dccm_wren), 64'h0);
            chk($sformatf("ares.empty_after%0d", i), 64'(stbuf_empty), 64'h1);
            @(posedge clk); #1;
        end

        // Randomized run against a queue model of the buffer (oldest at q[0]).
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic sv, frz, l, e_ready, e_wren, conf, mlo, mhi;
            logic [15:0] sa, a_lo, a_hi;
            logic [63:0] sd, mdlo, mdhi;
            string t;
            sv = 1'($urandom_range(0, 1));
            sa = rnd_addr();
            sd = {$urandom, $urandom};
            frz = ((cyc / 40) % 3 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 4) == 0);
            l = ($urandom_range(0, 4) < 2);
            a_lo = rnd_addr();
            a_hi = rnd_addr();
            if ($urandom_range(0, 2) == 0 && q.size() > 0) a_lo = {q[$urandom_range(0, q.size() - 1)].a, 3'b101};
            drive(sv, sa, sd, frz, l, a_lo, a_hi);
            #1;
            t = $sformatf("r%0d", cyc);
            e_ready = (q.size() != DEPTH);
            conf = 1'b0;
            if (q.size() > 0)
                conf = l && (q[0].a[2:0] == a_lo[5:3] || q[0].a[2:0] == a_hi[5:3]);
            e_wren = (q.size() > 0) && !frz && !conf;
            mlo = 1'b0; mhi = 1'b0; mdlo = '0; mdhi = '0;
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (!mlo && q[k].a == a_lo[15:3]) begin mlo = 1'b1; mdlo = q[k].d; end
                if (!mhi && q[k].a == a_hi[15:3]) begin mhi = 1'b1; mdhi = q[k].d; end
            end
            chk({t, ".ready"}, 64'(st_if.st_ready), 64'(e_ready));
            chk({t, ".empty"}, 64'(stbuf_empty), 64'(q.size() == 0));
            chk({t, ".wren"}, 64'(dccm_wren), 64'(e_wren));
            if (e_wren) begin
                chk({t, ".waddr"}, 64'(dccm_wr_addr), 64'({q[0].a, 3'b000}));
                chk({t, ".wdata"}, dccm_wr_data, q[0].d);
            end
            chk_fwd(t, l & mlo, mdlo, l & mhi, mdhi);
            if (e_wren) void'(q.pop_front());
            if (sv && e_ready) begin
                if (q.size() > 0 && q[q.size() - 1].a == sa[15:3]) begin
                    ment_t m;
                    m = q[q.size() - 1];
                    m.d = sd;
                    q[q.size() - 1] = m;
                end else begin
                    ment_t m;
                    m.a = sa[15:3];
                    m.d = sd;
                    q.push_back(m);
                end
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
